// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Brief    : Round-robin arbiter that shares one 4-bit ALU between NUM_REQ
//            requesters, one operation in flight, with a valid/ready response
//            carrying the result and the served requester's ID.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_sel,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_sel,
    input  logic [3:0]           alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [3:0]         r_op_a;
    logic [3:0]         r_op_b;
    logic [2:0]         r_op_sel;
    logic [ID_W-1:0]    r_op_id;
    logic [3:0]         r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_err;
    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [NUM_REQ-1:0] w_req_ready;

    logic [3:0] w_a   [NUM_REQ];
    logic [3:0] w_b   [NUM_REQ];
    logic [2:0] w_sel [NUM_REQ];

    // Index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two)
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_a[g]   = req_a[4*g +: 4];
            assign w_b[g]   = req_b[4*g +: 4];
            assign w_sel[g] = req_sel[3*g +: 3];
        end
    endgenerate

    // Winner search: first valid index at or after rr_ptr, wrapping upward
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_found)   w_next_state = c_EXEC;
            c_EXEC:                 w_next_state = c_RESP;
            c_RESP:  if (rsp_ready) w_next_state = c_IDLE;
            default:                w_next_state = c_IDLE;
        endcase
    end

    // Outputs decoded from state; the grant is a combinational one-hot in IDLE
    always_comb begin
        w_req_ready = '0;
        if (r_state == c_IDLE && w_found) w_req_ready[w_winner] = 1'b1;
        req_ready = w_req_ready;
        rsp_valid = (r_state == c_RESP);
        busy      = (r_state != c_IDLE);
    end

    // Operand capture on grant, result capture in EXEC, pointer advance on response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_sel   <= '0;
            r_op_id    <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_op_a   <= w_a[w_winner];
                        r_op_b   <= w_b[w_winner];
                        r_op_sel <= w_sel[w_winner];
                        r_op_id  <= w_winner;
                    end
                end
                c_EXEC: begin
                    r_rsp_data <= alu_out;
                    r_rsp_id   <= r_op_id;
                    r_rsp_err  <= (r_op_sel > 3'd4);
                end
                c_RESP: begin
                    // Pointer moves only once the response is consumed
                    if (rsp_ready) r_rr_ptr <= wrap_idx(r_op_id, 1);
                end
                default: ;
            endcase
        end
    end

    // Operand registers feed the ALU directly, so it sees no toggling while idle
    assign alu_a    = r_op_a;
    assign alu_b    = r_op_b;
    assign alu_sel  = r_op_sel;
    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;
    assign rsp_err  = r_rsp_err;

endmodule
`default_nettype wire
